// File: rtl/floppy_pkg.sv
// Shared floppy controller types: completion status codes and
// the sector-finder state encoding.
package floppy_pkg;

   typedef enum logic [2:0] {
      ST_OK          = 3'd0,
      ST_NOT_FOUND   = 3'd1,
      ST_WRONG_TRACK = 3'd2,
      ST_DATA_CRC    = 3'd3,
      ST_ABORTED     = 3'd4
   } status_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_ARMED  = 2'd2,
      S_READ   = 2'd3
   } fstate_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/sector_finder.sv
// Sector read sequencer: waits for a matching ID header, arms the
// data-field reader for a bounded byte window, reports one status.
//
// Ports:
//   i_Clk, i_Reset             clock, async active-high reset
//   i_Start, i_Abort           operation control
//   i_Track/i_Side/i_Sector    target, latched on accepted start
//   i_Index, i_ByteValid       index pulse, decoded-byte strobe
//   i_Hdr*                     parsed header results
//   i_Data*                    data-field reader events
//   o_Busy, o_DataArm          operation running, data reader enable
//   o_SectorSize               size code of the matched header
//   o_Done, o_Status           completion pulse and code
//   o_CRCErrCount              saturating header CRC error count
module sector_finder
   import floppy_pkg::*;
#(
   parameter int MAX_REVS   = 2,
   parameter int DAM_WINDOW = 43
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Start,
   input  logic       i_Abort,
   input  logic [7:0] i_Track,
   input  logic [7:0] i_Side,
   input  logic [7:0] i_Sector,
   input  logic       i_Index,
   input  logic       i_ByteValid,
   input  logic       i_HdrValid,
   input  logic       i_HdrCRCError,
   input  logic [7:0] i_HdrTrack,
   input  logic [7:0] i_HdrSide,
   input  logic [7:0] i_HdrSector,
   input  logic [7:0] i_HdrSize,
   input  logic       i_DataStart,
   input  logic       i_DataDone,
   input  logic       i_DataCRCError,
   output logic       o_Busy,
   output logic       o_DataArm,
   output logic [7:0] o_SectorSize,
   output logic       o_Done,
   output logic [2:0] o_Status,
   output logic [7:0] o_CRCErrCount
);

   localparam logic [3:0] REV_LIM = 4'(MAX_REVS);
   localparam logic [7:0] WIN_LIM = 8'(DAM_WINDOW);

   fstate_t    state_q, state_d;
   logic [7:0] trk_q, trk_d;
   logic [7:0] sid_q, sid_d;
   logic [7:0] sec_q, sec_d;
   logic [3:0] rev_q, rev_d;
   logic [7:0] byte_q, byte_d;
   logic [7:0] crc_q, crc_d;
   logic       wt_q, wt_d;
   logic [7:0] size_q, size_d;
   status_t    status_q, status_d;
   logic       done_q, done_d;

   logic       busy;
   logic       hit;
   logic       trk_miss;
   logic [3:0] rev_inc;
   logic [7:0] byte_inc;
   logic       rev_end;
   logic       fin;
   status_t    fin_st;

   assign busy     = (state_q != S_IDLE);
   assign hit      = i_HdrValid
                   && (i_HdrTrack  == trk_q)
                   && (i_HdrSide   == sid_q)
                   && (i_HdrSector == sec_q);
   assign trk_miss = i_HdrValid && (i_HdrTrack != trk_q);
   assign rev_inc  = sat_inc4(rev_q);
   assign byte_inc = byte_q + 8'd1;
   // rev_q can sit past the limit after a match on the last index,
   // so the next index in ARMED must still end the search.
   assign rev_end  = i_Index && (rev_inc >= REV_LIM);

   always_comb begin
      state_d  = state_q;
      trk_d    = trk_q;
      sid_d    = sid_q;
      sec_d    = sec_q;
      rev_d    = rev_q;
      byte_d   = byte_q;
      crc_d    = crc_q;
      wt_d     = wt_q;
      size_d   = size_q;
      status_d = status_q;
      done_d   = 1'b0;
      fin      = 1'b0;
      fin_st   = ST_OK;

      if (busy && i_Abort) begin
         fin    = 1'b1;
         fin_st = ST_ABORTED;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (i_Start) begin
                  state_d  = S_SEARCH;
                  trk_d    = i_Track;
                  sid_d    = i_Side;
                  sec_d    = i_Sector;
                  rev_d    = 4'd0;
                  crc_d    = 8'd0;
                  wt_d     = 1'b0;
                  status_d = ST_OK;
               end
            end
            S_SEARCH: begin
               if (i_Index)       rev_d = rev_inc;
               if (i_HdrCRCError) crc_d = sat_inc8(crc_q);
               if (hit) begin
                  size_d  = i_HdrSize;
                  byte_d  = 8'd0;
                  state_d = S_ARMED;
               end else begin
                  if (trk_miss) wt_d = 1'b1;
                  if (rev_end) begin
                     fin    = 1'b1;
                     fin_st = (wt_q || trk_miss) ?
                              ST_WRONG_TRACK : ST_NOT_FOUND;
                  end
               end
            end
            S_ARMED: begin
               if (i_Index)       rev_d = rev_inc;
               if (i_HdrCRCError) crc_d = sat_inc8(crc_q);
               if (i_DataStart) begin
                  state_d = S_READ;
               end else if (i_ByteValid) begin
                  byte_d = byte_inc;
                  if (byte_inc == WIN_LIM) state_d = S_SEARCH;
               end
               if (rev_end) begin
                  fin    = 1'b1;
                  fin_st = wt_q ? ST_WRONG_TRACK : ST_NOT_FOUND;
               end
            end
            S_READ: begin
               if (i_DataCRCError) begin
                  fin    = 1'b1;
                  fin_st = ST_DATA_CRC;
               end else if (i_DataDone) begin
                  fin    = 1'b1;
                  fin_st = ST_OK;
               end
            end
         endcase
      end

      if (fin) begin
         state_d  = S_IDLE;
         done_d   = 1'b1;
         status_d = fin_st;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= S_IDLE;
         trk_q    <= 8'd0;
         sid_q    <= 8'd0;
         sec_q    <= 8'd0;
         rev_q    <= 4'd0;
         byte_q   <= 8'd0;
         crc_q    <= 8'd0;
         wt_q     <= 1'b0;
         size_q   <= 8'd0;
         status_q <= ST_OK;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         trk_q    <= trk_d;
         sid_q    <= sid_d;
         sec_q    <= sec_d;
         rev_q    <= rev_d;
         byte_q   <= byte_d;
         crc_q    <= crc_d;
         wt_q     <= wt_d;
         size_q   <= size_d;
         status_q <= status_d;
         done_q   <= done_d;
      end
   end

   assign o_Busy        = busy;
   assign o_DataArm     = (state_q == S_ARMED) || (state_q == S_READ);
   assign o_SectorSize  = size_q;
   assign o_Done        = done_q;
   assign o_Status      = status_q;
   assign o_CRCErrCount = crc_q;

endmodule

// File: tb/tb_sector_finder.sv
// Directed bench for sector_finder: stimulus pushes expected
// completions, a negedge monitor pops and compares them.
module tb_sector_finder;

   logic       i_Clk = 1'b0;
   logic       i_Reset = 1'b1;
   logic       i_Start = 1'b0;
   logic       i_Abort = 1'b0;
   logic [7:0] i_Track = 8'd0;
   logic [7:0] i_Side = 8'd0;
   logic [7:0] i_Sector = 8'd0;
   logic       i_Index = 1'b0;
   logic       i_ByteValid = 1'b0;
   logic       i_HdrValid = 1'b0;
   logic       i_HdrCRCError = 1'b0;
   logic [7:0] i_HdrTrack = 8'd0;
   logic [7:0] i_HdrSide = 8'd0;
   logic [7:0] i_HdrSector = 8'd0;
   logic [7:0] i_HdrSize = 8'd0;
   logic       i_DataStart = 1'b0;
   logic       i_DataDone = 1'b0;
   logic       i_DataCRCError = 1'b0;
   logic       o_Busy;
   logic       o_DataArm;
   logic [7:0] o_SectorSize;
   logic       o_Done;
   logic [2:0] o_Status;
   logic [7:0] o_CRCErrCount;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [2:0] st;
      logic [7:0] sz;
      logic [7:0] crc;
   } exp_t;

   exp_t exp_q[$];

   sector_finder #(.MAX_REVS(2), .DAM_WINDOW(43)) dut (
      .i_Clk(i_Clk), .i_Reset(i_Reset),
      .i_Start(i_Start), .i_Abort(i_Abort),
      .i_Track(i_Track), .i_Side(i_Side), .i_Sector(i_Sector),
      .i_Index(i_Index), .i_ByteValid(i_ByteValid),
      .i_HdrValid(i_HdrValid), .i_HdrCRCError(i_HdrCRCError),
      .i_HdrTrack(i_HdrTrack), .i_HdrSide(i_HdrSide),
      .i_HdrSector(i_HdrSector), .i_HdrSize(i_HdrSize),
      .i_DataStart(i_DataStart), .i_DataDone(i_DataDone),
      .i_DataCRCError(i_DataCRCError),
      .o_Busy(o_Busy), .o_DataArm(o_DataArm),
      .o_SectorSize(o_SectorSize), .o_Done(o_Done),
      .o_Status(o_Status), .o_CRCErrCount(o_CRCErrCount)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge i_Clk) begin
      if (o_Done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("status", 32'(o_Status), 32'(e.st));
            chk("size", 32'(o_SectorSize), 32'(e.sz));
            chk("crccnt", 32'(o_CRCErrCount), 32'(e.crc));
         end
      end
   end

   task automatic cyc();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic start(input logic [7:0] t, input logic [7:0] s,
                        input logic [7:0] c);
      i_Start = 1'b1;
      i_Track = t;
      i_Side = s;
      i_Sector = c;
      cyc();
      i_Start = 1'b0;
   endtask

   task automatic hdr(input logic [7:0] t, input logic [7:0] s,
                      input logic [7:0] c, input logic [7:0] z);
      i_HdrValid = 1'b1;
      i_HdrTrack = t;
      i_HdrSide = s;
      i_HdrSector = c;
      i_HdrSize = z;
      cyc();
      i_HdrValid = 1'b0;
   endtask

   task automatic index_p();
      i_Index = 1'b1;
      cyc();
      i_Index = 1'b0;
   endtask

   task automatic push(input logic [2:0] st, input logic [7:0] sz,
                       input logic [7:0] crc);
      exp_t e;
      e.st = st;
      e.sz = sz;
      e.crc = crc;
      exp_q.push_back(e);
   endtask

   initial begin
      cyc();
      cyc();
      i_Reset = 1'b0;
      cyc();
      chk("rst_busy", 32'(o_Busy), 0);
      chk("rst_arm", 32'(o_DataArm), 0);
      chk("rst_done", 32'(o_Done), 0);
      chk("rst_status", 32'(o_Status), 0);
      chk("rst_size", 32'(o_SectorSize), 0);
      chk("rst_crc", 32'(o_CRCErrCount), 0);

      // good read of sector 3
      start(8'd5, 8'd0, 8'd3);
      chk("t1_busy", 32'(o_Busy), 1);
      hdr(8'd5, 8'd0, 8'd1, 8'd1);
      hdr(8'd5, 8'd0, 8'd2, 8'd1);
      chk("t1_noarm", 32'(o_DataArm), 0);
      hdr(8'd5, 8'd0, 8'd3, 8'd2);
      chk("t1_arm", 32'(o_DataArm), 1);
      i_DataStart = 1'b1;
      cyc();
      i_DataStart = 1'b0;
      push(3'd0, 8'd2, 8'd0);
      i_DataDone = 1'b1;
      cyc();
      i_DataDone = 1'b0;
      chk("t1_done", 32'(o_Done), 1);
      chk("t1_idle", 32'(o_Busy), 0);
      cyc();
      chk("t1_pulse1", 32'(o_Done), 0);

      // sector never appears -> not found
      start(8'd5, 8'd0, 8'd9);
      for (int i = 1; i <= 8; i++) hdr(8'd5, 8'd0, 8'(i), 8'd1);
      index_p();
      chk("t2_busy_rev1", 32'(o_Busy), 1);
      push(3'd1, 8'd2, 8'd0);
      index_p();
      chk("t2_done", 32'(o_Done), 1);
      cyc();

      // only wrong track seen
      start(8'd5, 8'd0, 8'd1);
      hdr(8'd7, 8'd0, 8'd1, 8'd3);
      index_p();
      push(3'd2, 8'd2, 8'd0);
      index_p();
      cyc();

      // data mark window expires, then a retry with bad data CRC
      start(8'd5, 8'd1, 8'd4);
      hdr(8'd5, 8'd1, 8'd4, 8'd1);
      chk("t4_size1", 32'(o_SectorSize), 1);
      i_ByteValid = 1'b1;
      repeat (42) cyc();
      chk("t4_arm42", 32'(o_DataArm), 1);
      cyc();
      i_ByteValid = 1'b0;
      chk("t4_arm43", 32'(o_DataArm), 0);
      chk("t4_busy43", 32'(o_Busy), 1);
      hdr(8'd5, 8'd1, 8'd4, 8'd3);
      chk("t4_rearm", 32'(o_DataArm), 1);
      i_DataStart = 1'b1;
      cyc();
      i_DataStart = 1'b0;
      push(3'd3, 8'd3, 8'd0);
      i_DataCRCError = 1'b1;
      i_DataDone = 1'b1;
      cyc();
      i_DataCRCError = 1'b0;
      i_DataDone = 1'b0;
      cyc();

      // CRC counter saturation, abort, abort in idle
      start(8'd5, 8'd0, 8'd9);
      i_HdrCRCError = 1'b1;
      repeat (300) cyc();
      i_HdrCRCError = 1'b0;
      chk("t5_crc_sat", 32'(o_CRCErrCount), 255);
      push(3'd4, 8'd3, 8'd255);
      i_Abort = 1'b1;
      cyc();
      i_Abort = 1'b0;
      cyc();
      i_Abort = 1'b1;
      cyc();
      i_Abort = 1'b0;
      cyc();
      chk("t5_status_hold", 32'(o_Status), 4);

      // match together with the last index -> armed, no done
      start(8'd5, 8'd0, 8'd3);
      index_p();
      i_Index = 1'b1;
      hdr(8'd5, 8'd0, 8'd3, 8'd2);
      i_Index = 1'b0;
      chk("t6_arm", 32'(o_DataArm), 1);
      chk("t6_busy", 32'(o_Busy), 1);
      cyc();
      chk("t6_nodone", 32'(o_Done), 0);
      i_DataStart = 1'b1;
      cyc();
      i_DataStart = 1'b0;
      push(3'd0, 8'd2, 8'd0);
      i_DataDone = 1'b1;
      cyc();
      i_DataDone = 1'b0;
      cyc();

      // start while busy is ignored
      start(8'd5, 8'd0, 8'd3);
      start(8'd9, 8'd9, 8'd9);
      hdr(8'd9, 8'd9, 8'd9, 8'd4);
      chk("t7_nomatch", 32'(o_DataArm), 0);
      hdr(8'd5, 8'd0, 8'd3, 8'd1);
      chk("t7_arm", 32'(o_DataArm), 1);
      chk("t7_size", 32'(o_SectorSize), 1);
      i_DataStart = 1'b1;
      cyc();
      i_DataStart = 1'b0;

      // async reset in READ
      i_Reset = 1'b1;
      #1;
      chk("t8_busy", 32'(o_Busy), 0);
      chk("t8_arm", 32'(o_DataArm), 0);
      chk("t8_done", 32'(o_Done), 0);
      chk("t8_size", 32'(o_SectorSize), 0);
      chk("t8_status", 32'(o_Status), 0);
      cyc();
      i_Reset = 1'b0;
      repeat (5) cyc();

      chk("pending", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule

// File: doc/sector_finder.md
Name: sector_finder

Overview:
Sequences one sector read operation on top of the header parser and the data-field reader. It latches a target (track, side, sector) and watches parsed ID headers until one matches. It then arms the data-field reader for a bounded byte window and reports a single completion status. Index pulses bound the search to a fixed number of revolutions, and header CRC failures are counted for diagnostics.

Parameters:
MAX_REVS, 2, number of index pulses in one operation before the search ends as not-found (1..15)
DAM_WINDOW, 43, number of decoded bytes after a header match within which the data mark must start (1..255)

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Start  in  1  one-cycle request to begin an operation; sampled only in IDLE
i_Abort  in  1  one-cycle request to cancel the current operation
i_Track  in  8  target track, latched on accepted i_Start
i_Side  in  8  target side, latched on accepted i_Start
i_Sector  in  8  target sector, latched on accepted i_Start
i_Index  in  1  one-cycle index pulse, already synchronised
i_ByteValid  in  1  decoded-byte strobe from the MFM decoder
i_HdrValid  in  1  one-cycle pulse: header parsed with good CRC
i_HdrCRCError  in  1  one-cycle pulse: header CRC mismatch
i_HdrTrack  in  8  parsed track, valid with i_HdrValid
i_HdrSide  in  8  parsed side, valid with i_HdrValid
i_HdrSector  in  8  parsed sector, valid with i_HdrValid
i_HdrSize  in  8  parsed size code, valid with i_HdrValid
i_DataStart  in  1  data reader found the data address mark
i_DataDone  in  1  data reader finished the field with good CRC
i_DataCRCError  in  1  data reader finished the field with bad CRC
o_Busy  out  1  operation in progress
o_DataArm  out  1  enables the data-field reader
o_SectorSize  out  8  size code of the matched header
o_Done  out  1  one-cycle completion pulse
o_Status  out  3  completion code; valid from o_Done until the next accepted start
o_CRCErrCount  out  8  header CRC errors seen in this operation, saturating at 255

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0.
- States and transitions:
  - IDLE -> SEARCH on i_Start.
    - Latch the target; clear the revolution counter, o_CRCErrCount, the wrong-track flag and o_Status.
    - o_Busy goes to 1 on the next cycle.
  - SEARCH:
    - i_HdrValid with all three fields equal to the target: latch o_SectorSize, clear the byte counter, go to ARMED with o_DataArm=1 on the next cycle.
    - i_HdrValid with a track mismatch: set the sticky wrong-track flag.
    - i_HdrValid matching track but a different side or sector: no action.
  - ARMED:
    - i_DataStart: go to READ.
    - Every i_ByteValid increments the byte counter. When it reaches DAM_WINDOW without i_DataStart, drop o_DataArm and return to SEARCH.
    - If i_ByteValid and i_DataStart occur in the same cycle, i_DataStart wins.
  - READ:
    - i_DataDone: finish with OK.
    - i_DataCRCError: finish with DATA_CRC.
    - If both occur in the same cycle, DATA_CRC wins.
    - The revolution limit does not apply in READ.
- Revolution limit (SEARCH and ARMED):
  - Each i_Index increments the revolution counter.
  - When the count reaches MAX_REVS: finish with WRONG_TRACK if the wrong-track flag is set, otherwise NOT_FOUND.
  - If a header match and i_Index occur in the same cycle, the match wins and the index is still counted.
- Header CRC counting: i_HdrCRCError in SEARCH or ARMED increments o_CRCErrCount, saturating at 255.
- Finish (from any busy state):
  - Next cycle: o_Done=1 for exactly one cycle, o_Status loaded, o_Busy=0, o_DataArm=0, state IDLE.
- Abort: i_Abort in any busy state finishes with ABORTED; it takes priority over all other events that cycle. In IDLE it is ignored.
- i_Start while busy is ignored. i_Start in the same cycle as o_Done is accepted, because the state is already IDLE.
- Asynchronous reset mid-operation returns to IDLE with no o_Done pulse.
- Header and data inputs are ignored in IDLE.

Decomposition:
- Shared package floppy_pkg holds:
  - status codes: ST_OK=0, ST_NOT_FOUND=1, ST_WRONG_TRACK=2, ST_DATA_CRC=3, ST_ABORTED=4;
  - the state encoding: IDLE, SEARCH, ARMED, READ.
- No sub-module: the byte-window and revolution counters stay inline.

Test Plan:
- Start T=5/S=0/Sec=3. Feed headers for sectors 1, 2, 3, then i_DataStart, then i_DataDone -> o_Done pulse, o_Status=0, o_SectorSize equals the sector-3 size code (2), o_CRCErrCount=0.
- Start Sec=9. Feed only sectors 1..8 on track 5, then 2 index pulses -> o_Done on the cycle after the second index, o_Status=1.
- Start T=5. Feed headers with track 7 and 2 index pulses -> o_Status=2.
- Match, then 43 byte strobes without i_DataStart -> o_DataArm falls and the search resumes. Second match, then i_DataStart, then i_DataCRCError -> o_Status=3.
- 300 i_HdrCRCError pulses during SEARCH -> o_CRCErrCount=255. Then i_Abort -> o_Status=4, and a second i_Abort in IDLE produces no pulse.
- Simultaneous events, each checked separately:
  - Matching i_HdrValid and the MAX_REVS-th i_Index in the same cycle -> enters ARMED, no o_Done.
  - i_Start while busy -> no effect.
  - i_Reset in READ -> all outputs 0, no o_Done.
